// File: rtl/fft32_sdf_ctrl.sv
// rtl/fft32_sdf_ctrl.sv - sequencing controller for a 32-point R2SDF FFT pipeline
module fft32_sdf_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        en,
    output logic [4:0]  bf_sel,
    output logic [19:0] tw_addr,
    output logic        out_valid,
    output logic [4:0]  out_index,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, STALL, DRAIN} state_t;

    state_t      state, state_nx;
    logic [35:0] vline, vline_after;
    logic [4:0]  cnt0;
    logic [4:0]  p0;
    logic [4:0]  p5;

    // Only the bits feeding bf_sel/tw_addr are kept; low bits wrap identically.
    logic [3:0]  cnt1;
    logic [2:0]  cnt2;
    logic [1:0]  cnt3;
    logic        cnt4;
    logic [3:0]  p1;
    logic [2:0]  p2;
    logic [1:0]  p3;

    logic        v_in1, v_in2, v_in3, v_in4;
    logic        v_out0, v_out1, v_out2, v_out3;

    assign v_in1  = vline[16];
    assign v_in2  = vline[25];
    assign v_in3  = vline[30];
    assign v_in4  = vline[33];
    assign v_out0 = vline[15];
    assign v_out1 = vline[24];
    assign v_out2 = vline[29];
    assign v_out3 = vline[32];

    assign en          = !rst && (in_valid || (cnt0 == 5'd0 && |vline));
    assign vline_after = en ? {vline[34:0], in_valid} : vline;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            vline <= '0;
            cnt0  <= '0;
            cnt1  <= '0;
            cnt2  <= '0;
            cnt3  <= '0;
            cnt4  <= 1'b0;
            p0    <= '0;
            p1    <= '0;
            p2    <= '0;
            p3    <= '0;
            p5    <= '0;
        end else begin
            state <= state_nx;
            vline <= vline_after;
            if (en) begin
                if (in_valid) cnt0 <= cnt0 + 5'd1;
                if (v_in1)    cnt1 <= cnt1 + 4'd1;
                if (v_in2)    cnt2 <= cnt2 + 3'd1;
                if (v_in3)    cnt3 <= cnt3 + 2'd1;
                if (v_in4)    cnt4 <= ~cnt4;
                if (v_out0)   p0   <= p0 + 5'd1;
                if (v_out1)   p1   <= p1 + 4'd1;
                if (v_out2)   p2   <= p2 + 3'd1;
                if (v_out3)   p3   <= p3 + 2'd1;
                if (vline[35]) p5  <= p5 + 5'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (!in_valid) begin
                    if (cnt0 != 5'd0)            state_nx = STALL;
                    else if (vline_after == '0)  state_nx = IDLE;
                    else                         state_nx = DRAIN;
                end
            end
            STALL: begin
                if (in_valid) state_nx = RUN;
            end
            DRAIN: begin
                if (in_valid)                state_nx = RUN;
                else if (vline_after == '0)  state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bf_sel = {cnt4, cnt3[1], cnt2[2], cnt1[3], cnt0[4]};

    // Twiddle index k for stage s is the low (4-s) position bits scaled by 2^s.
    assign tw_addr[3:0]   = p0[4] ? p0[3:0] : 4'd0;
    assign tw_addr[7:4]   = p1[3] ? {p1[2:0], 1'b0} : 4'd0;
    assign tw_addr[11:8]  = p2[2] ? {p2[1:0], 2'b0} : 4'd0;
    assign tw_addr[15:12] = p3[1] ? {p3[0], 3'b0} : 4'd0;
    assign tw_addr[19:16] = 4'd0;

    assign out_valid  = en && vline[35];
    assign out_index  = {p5[0], p5[1], p5[2], p5[3], p5[4]};
    assign frame_done = out_valid && (p5 == 5'd31);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fft32_sdf_ctrl.sv
// tb/tb_fft32_sdf_ctrl.sv - self-checking bench for fft32_sdf_ctrl against an event-time model
module tb_fft32_sdf_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        en;
    logic [4:0]  bf_sel;
    logic [19:0] tw_addr;
    logic        out_valid;
    logic [4:0]  out_index;
    logic        frame_done;
    logic        busy;

    fft32_sdf_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .en(en), .bf_sel(bf_sel),
        .tw_addr(tw_addr), .out_valid(out_valid), .out_index(out_index),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: en-cycle time of every accepted sample since reset; list index = arrival order.
    int ts[$];
    int e_now;
    int n_assert = 0;
    int n_fail = 0;
    int cyc;
    int first_ov;
    int ov_cnt;
    int fd_q[$];

    localparam int OFS[5] = '{0, 17, 26, 31, 34};
    localparam int DEP[5] = '{16, 8, 4, 2, 1};

    function automatic int cnt_lt(input int off);
        int c = 0;
        foreach (ts[i]) if (ts[i] + off < e_now) c++;
        return c;
    endfunction

    function automatic int bitrev5(input int v);
        int r = 0;
        for (int b = 0; b < 5; b++) if ((v >> b) & 1) r |= 1 << (4 - b);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic iv);
        int n, inflight, outs, e_en, e_ov, e_bf, e_tw, pc;
        in_valid = iv;
        @(negedge clk);
        n        = ts.size();
        inflight = (cnt_lt(0) - cnt_lt(36)) > 0;
        outs     = cnt_lt(36);
        e_en     = iv || ((n % 32) == 0 && inflight);
        e_ov     = e_en && (cnt_lt(35) - outs) > 0;
        e_bf     = 0;
        e_tw     = 0;
        for (int s = 0; s < 5; s++) begin
            e_bf |= ((cnt_lt(OFS[s]) >> (4 - s)) & 1) << s;
            pc = cnt_lt(OFS[s] + DEP[s]) % 32;
            if ((pc >> (4 - s)) & 1)
                e_tw |= ((pc % (1 << (4 - s))) << s) << (4 * s);
        end
        chk("en", en, e_en);
        chk("out_valid", out_valid, e_ov);
        chk("out_index", out_index, bitrev5(outs % 32));
        chk("frame_done", frame_done, e_ov && (outs % 32) == 31);
        chk("busy", busy, inflight || (n % 32) != 0);
        chk("bf_sel", bf_sel, e_bf);
        chk("tw_addr", tw_addr, e_tw);
        if (out_valid) begin
            if (first_ov < 0) first_ov = cyc;
            ov_cnt++;
        end
        if (frame_done) fd_q.push_back(cyc);
        if (e_en) begin
            if (iv) ts.push_back(e_now);
            e_now++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input logic iv, input int len);
        for (int i = 0; i < len; i++) step(iv);
    endtask

    task automatic scen_start();
        cyc = 0;
        first_ov = -1;
        ov_cnt = 0;
        fd_q.delete();
    endtask

    task automatic do_reset(input logic iv);
        rst = 1'b1;
        in_valid = iv;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ts.delete();
        e_now = 0;
    endtask

    initial begin
        int on_len, off_len;
        rst = 1'b1;
        in_valid = 1'b0;
        e_now = 0;
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // Single frame
        scen_start();
        run(1'b1, 32);
        run(1'b0, 40);
        chk("s1_first_out", first_ov, 36);
        chk("s1_out_count", ov_cnt, 32);
        chk("s1_fd_count", fd_q.size(), 1);
        if (fd_q.size() > 0) chk("s1_fd_cycle", fd_q[0], 67);

        // Two back-to-back frames
        do_reset(1'b0);
        scen_start();
        run(1'b1, 64);
        run(1'b0, 40);
        chk("b2b_first_out", first_ov, 36);
        chk("b2b_out_count", ov_cnt, 64);
        chk("b2b_fd_count", fd_q.size(), 2);
        if (fd_q.size() > 1) begin
            chk("b2b_fd0", fd_q[0], 67);
            chk("b2b_fd1", fd_q[1], 99);
        end

        // Mid-frame stall at cnt0=10
        do_reset(1'b0);
        scen_start();
        run(1'b1, 10);
        run(1'b0, 5);
        run(1'b1, 22);
        run(1'b0, 45);
        chk("stall_first_out", first_ov, 41);
        chk("stall_out_count", ov_cnt, 32);

        // Drain then restart during drain
        do_reset(1'b0);
        scen_start();
        run(1'b1, 32);
        run(1'b0, 8);
        run(1'b1, 32);
        run(1'b0, 80);
        chk("drain_out_count", ov_cnt, 64);
        chk("drain_fd_count", fd_q.size(), 2);
        if (fd_q.size() > 1) begin
            chk("drain_fd0", fd_q[0], 67);
            chk("drain_fd1", fd_q[1], 107);
        end

        // Reset during a frame, then a fresh frame
        do_reset(1'b0);
        scen_start();
        run(1'b1, 20);
        do_reset(1'b1);
        scen_start();
        step(1'b0);
        chk("rst_out_count", ov_cnt, 0);
        scen_start();
        run(1'b1, 32);
        run(1'b0, 40);
        chk("rst_s1_first_out", first_ov, 36);
        chk("rst_s1_out_count", ov_cnt, 32);
        if (fd_q.size() > 0) chk("rst_s1_fd_cycle", fd_q[0], 67);

        // Randomized bursts with stalls and occasional full drains
        do_reset(1'b0);
        scen_start();
        for (int k = 0; k < 40; k++) begin
            on_len  = $urandom_range(1, 40);
            off_len = ($urandom_range(0, 5) == 0) ? 45 : $urandom_range(0, 12);
            run(1'b1, on_len);
            run(1'b0, off_len);
        end
        while (ts.size() % 32 != 0) step(1'b1);
        run(1'b0, 45);
        chk("rand_out_count", ov_cnt, ts.size());
        chk("rand_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
